// File: rtl/door_motor_drv.sv
// door_motor_drv: H-bridge driver placed after the door-control FSM.
// It turns the level-type open/close requests into bridge drive and enforces
// a dead time before any drive starts. A soft-start PWM ramp is applied, and
// a run-time watchdog latches a fault when a run lasts too long.
// Optional feature macro: DOOR_DRV_SOFTSTART_EN. When it is defined, the duty
// ramps up from RAMP_STEP. When it is not defined, drive is at full duty for
// the whole run.
module door_motor_drv #(
  parameter int DEAD_CYCLES     = 16,
  parameter int PWM_BITS        = 8,
  parameter int RAMP_STEP       = 8,
  parameter int TIMEOUT_PERIODS = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              ma_req,
  input  logic              mc_req,
  input  logic              fault_clr,
  output logic              pwm_a,
  output logic              pwm_c,
  output logic              busy,
  output logic              fault,
  output logic [PWM_BITS:0] duty
);

  typedef enum logic [2:0] {IDLE, DEAD, RUN_A, RUN_C, FAULT} state_t;

  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DCW-1:0]      DCNT_LAST = DCW'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PCNT_MAX  = '1;
  localparam logic [PWM_BITS:0]   DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [15:0]         TCNT_LAST = 16'(TIMEOUT_PERIODS - 1);

`ifdef DOOR_DRV_SOFTSTART_EN
  localparam logic [PWM_BITS+1:0] STEP_W     = (PWM_BITS + 2)'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   DUTY_START = STEP_W[PWM_BITS:0];
`else
  localparam logic [PWM_BITS:0]   DUTY_START = DUTY_FULL;
`endif

  state_t              state, state_n;
  logic                dir_c, dir_c_n;
  logic [DCW-1:0]      dcnt, dcnt_n;
  logic [PWM_BITS-1:0] pcnt, pcnt_n;
  logic [PWM_BITS:0]   duty_q, duty_n;
  logic [15:0]         tcnt, tcnt_n;
  logic                own_req, other_req;

`ifdef DOOR_DRV_SOFTSTART_EN
  logic [PWM_BITS+1:0] duty_sum;
  logic [PWM_BITS:0]   duty_ramp;

  // Next ramp value: add one step and saturate at 100 % duty.
  always_comb begin
    duty_sum  = {1'b0, duty_q} + STEP_W;
    duty_ramp = duty_q;
    if (duty_sum > {1'b0, DUTY_FULL}) begin
      duty_ramp = DUTY_FULL;
    end else begin
      duty_ramp = duty_sum[PWM_BITS:0];
    end
  end
`endif

  // State and datapath registers; a low ena freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dir_c  <= 1'b0;
      dcnt   <= '0;
      pcnt   <= '0;
      duty_q <= '0;
      tcnt   <= '0;
    end else if (ena) begin
      state  <= state_n;
      dir_c  <= dir_c_n;
      dcnt   <= dcnt_n;
      pcnt   <= pcnt_n;
      duty_q <= duty_n;
      tcnt   <= tcnt_n;
    end
  end

  // Next-state logic. The conflict check comes first and overrides everything else.
  always_comb begin
    state_n   = state;
    dir_c_n   = dir_c;
    dcnt_n    = dcnt;
    pcnt_n    = pcnt;
    duty_n    = duty_q;
    tcnt_n    = tcnt;
    own_req   = dir_c ? mc_req : ma_req;
    other_req = dir_c ? ma_req : mc_req;

    if (ma_req && mc_req) begin
      state_n = FAULT;
      dcnt_n  = '0;
      pcnt_n  = '0;
      duty_n  = '0;
      tcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ma_req != mc_req) begin
            state_n = DEAD;
            dir_c_n = mc_req;
            dcnt_n  = '0;
          end
        end
        DEAD: begin
          if (!own_req) begin
            state_n = IDLE;
            dcnt_n  = '0;
          end else if (dcnt == DCNT_LAST) begin
            state_n = dir_c ? RUN_C : RUN_A;
            dcnt_n  = '0;
            pcnt_n  = '0;
            duty_n  = DUTY_START;
            tcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + DCW'(1);
          end
        end
        RUN_A, RUN_C: begin
          if (pcnt == PCNT_MAX && tcnt == TCNT_LAST) begin
            state_n = FAULT;
            pcnt_n  = '0;
            duty_n  = '0;
            tcnt_n  = '0;
          end else if (!own_req || other_req) begin
            state_n = IDLE;
            pcnt_n  = '0;
            duty_n  = '0;
            tcnt_n  = '0;
          end else begin
            pcnt_n = pcnt + PWM_BITS'(1);
            if (pcnt == PCNT_MAX) begin
              tcnt_n = tcnt + 16'd1;
`ifdef DOOR_DRV_SOFTSTART_EN
              duty_n = duty_ramp;
`endif
            end
          end
        end
        FAULT: begin
          if (fault_clr && !ma_req && !mc_req) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          pcnt_n  = '0;
          duty_n  = '0;
          tcnt_n  = '0;
          dcnt_n  = '0;
        end
      endcase
    end
  end

  // Output decode. It uses registered values only, so the bridge pins never glitch on inputs.
  always_comb begin
    pwm_a = (state == RUN_A) && ({1'b0, pcnt} < duty_q);
    pwm_c = (state == RUN_C) && ({1'b0, pcnt} < duty_q);
    busy  = (state == DEAD) || (state == RUN_A) || (state == RUN_C);
    fault = (state == FAULT);
    duty  = duty_q;
  end

endmodule

// File: tb/tb_door_motor_drv.sv
// tb_door_motor_drv: scoreboard bench for door_motor_drv.
// A behavioural model predicts the outputs after every clock edge. The
// monitor pops each prediction and compares it with the DUT.
module tb_door_motor_drv;

  localparam int DC     = 4;
  localparam int PB     = 4;
  localparam int RS     = 4;
  localparam int TO     = 8;
  localparam int PERIOD = 1 << PB;

  typedef struct packed {
    logic        pa;
    logic        pc;
    logic        busy;
    logic        fault;
    logic [PB:0] duty;
  } exp_t;

  typedef enum {M_IDLE, M_DEAD, M_RUN, M_FAULT} mmode_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        ma_req;
  logic        mc_req;
  logic        fault_clr;
  logic        pwm_a;
  logic        pwm_c;
  logic        busy;
  logic        fault;
  logic [PB:0] duty;

  exp_t   exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  mmode_t m_mode;
  bit     m_to_c;
  int     m_dead;
  int     m_run;

  door_motor_drv #(
    .DEAD_CYCLES(DC), .PWM_BITS(PB), .RAMP_STEP(RS), .TIMEOUT_PERIODS(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ma_req(ma_req), .mc_req(mc_req),
    .fault_clr(fault_clr), .pwm_a(pwm_a), .pwm_c(pwm_c), .busy(busy),
    .fault(fault), .duty(duty)
  );

  always #5 clk = ~clk;

  // Model reset: idle, with nothing latched.
  task automatic modelReset();
    m_mode = M_IDLE;
    m_to_c = 1'b0;
    m_dead = 0;
    m_run  = 0;
  endtask

  // One clock edge of the model.
  // m_dead counts edges spent in the dead time.
  // m_run counts edges since RUN entry.
  task automatic modelStep(input bit ma, input bit mc, input bit clr, input bit en);
    bit own;
    bit other;
    if (!en) return;
    if (ma && mc) begin
      m_mode = M_FAULT;
      return;
    end
    own   = m_to_c ? mc : ma;
    other = m_to_c ? ma : mc;
    case (m_mode)
      M_IDLE: if (ma != mc) begin
        m_mode = M_DEAD;
        m_to_c = mc;
        m_dead = 0;
      end
      M_DEAD: begin
        if (!own) m_mode = M_IDLE;
        else if (m_dead == DC - 1) begin
          m_mode = M_RUN;
          m_run  = 0;
        end else m_dead++;
      end
      M_RUN: begin
        if (m_run == TO * PERIOD - 1) m_mode = M_FAULT;
        else if (!own || other) m_mode = M_IDLE;
        else m_run++;
      end
      M_FAULT: if (clr && !ma && !mc) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Expected duty after m_run cycles of running.
  function automatic int dutyOf(input int run);
    int d;
`ifdef DOOR_DRV_SOFTSTART_EN
    d = RS * (run / PERIOD + 1);
    if (d > PERIOD) d = PERIOD;
`else
    d = PERIOD;
`endif
    return d;
  endfunction

  // Expected output set for the current model state.
  function automatic exp_t modelOut();
    exp_t e;
    int   d;
    e = '0;
    case (m_mode)
      M_DEAD: e.busy = 1'b1;
      M_RUN: begin
        d      = dutyOf(m_run);
        e.busy = 1'b1;
        e.duty = (PB + 1)'(d);
        e.pa   = !m_to_c && ((m_run % PERIOD) < d);
        e.pc   = m_to_c && ((m_run % PERIOD) < d);
      end
      M_FAULT: e.fault = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // Compare the DUT outputs with one expected output set.
  task automatic checkOutput(input string name, input exp_t e);
    exp_t got;
    got = '{pa: pwm_a, pc: pwm_c, busy: busy, fault: fault, duty: duty};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got pa=%b pc=%b busy=%b fault=%b duty=%0d required pa=%b pc=%b busy=%b fault=%b duty=%0d",
               name, $time, got.pa, got.pc, got.busy, got.fault, got.duty,
               e.pa, e.pc, e.busy, e.fault, e.duty);
    end
  endtask

  // Drive one cycle of inputs and queue what the next edge must produce.
  task automatic applyStimulus(input bit ma, input bit mc, input bit clr, input bit en);
    @(negedge clk);
    ma_req    = ma;
    mc_req    = mc;
    fault_clr = clr;
    ena       = en;
    modelStep(ma, mc, clr, en);
    exp_q.push_back(modelOut());
  endtask

  // Apply the same inputs for n cycles.
  task automatic holdFor(input int n, input bit ma, input bit mc, input bit clr, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(ma, mc, clr, en);
  endtask

  // Pulse reset between clock edges.
  // The outputs must clear with no edge at all.
  task automatic resetPulse();
    @(negedge clk);
    ma_req    = 1'b0;
    mc_req    = 1'b0;
    fault_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", '0);
    #1 rst_n = 1'b1;
    modelReset();
    modelStep(1'b0, 1'b0, 1'b0, ena);
    exp_q.push_back(modelOut());
  endtask

  // Monitor: after every active edge, pop the prediction and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput("edge_output", exp_q.pop_front());
    end
  end

  // Stimulus: directed scenarios first, then randomized segments.
  initial begin
    int pat;
    int len;
    bit ma;
    bit mc;
    rst_n     = 1'b0;
    ena       = 1'b1;
    ma_req    = 1'b0;
    mc_req    = 1'b0;
    fault_clr = 1'b0;
    modelReset();
    #1 checkOutput("reset_values", '0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] directed: open run with ramp");
    holdFor(DC + 5 * PERIOD, 1'b1, 1'b0, 1'b0, 1'b1);
    $display("[TB] directed: reversal through dead time");
    holdFor(30, 1'b0, 1'b1, 1'b0, 1'b1);
    resetPulse();
    $display("[TB] directed: timeout and fault clear");
    holdFor(DC + TO * PERIOD + 5, 1'b1, 1'b0, 1'b0, 1'b1);
    holdFor(3, 1'b1, 1'b0, 1'b1, 1'b1);
    holdFor(2, 1'b0, 1'b0, 1'b0, 1'b1);
    holdFor(2, 1'b0, 1'b0, 1'b1, 1'b1);
    $display("[TB] directed: conflicts");
    holdFor(1, 1'b1, 1'b1, 1'b0, 1'b1);
    holdFor(2, 1'b0, 1'b0, 1'b1, 1'b1);
    holdFor(30, 1'b0, 1'b1, 1'b0, 1'b1);
    holdFor(1, 1'b1, 1'b1, 1'b0, 1'b1);
    holdFor(2, 1'b0, 1'b0, 1'b1, 1'b1);
    $display("[TB] directed: clock enable freeze");
    holdFor(25, 1'b1, 1'b0, 1'b0, 1'b1);
    holdFor(5, 1'b1, 1'b0, 1'b0, 1'b0);
    holdFor(3, 1'b1, 1'b1, 1'b1, 1'b0);
    holdFor(10, 1'b1, 1'b0, 1'b0, 1'b1);
    holdFor(2, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] randomized segments");
    for (int s = 0; s < 80; s++) begin
      pat = $urandom_range(9, 0);
      len = ($urandom_range(9, 0) == 0) ? $urandom_range(160, 120) : $urandom_range(40, 1);
      case (pat)
        0, 1, 2: begin ma = 1'b1; mc = 1'b0; end
        3, 4, 5: begin ma = 1'b0; mc = 1'b1; end
        6, 7:    begin ma = 1'b0; mc = 1'b0; end
        default: begin ma = 1'b1; mc = 1'b1; len = 1; end
      endcase
      for (int i = 0; i < len; i++) begin
        applyStimulus(ma, mc, ($urandom_range(3, 0) == 0), ($urandom_range(19, 0) != 0));
      end
      if ($urandom_range(14, 0) == 0) resetPulse();
    end

    holdFor(2, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
